// File: rtl/dm_responder_pkg.sv
// Shared CPU constants for the data-memory responder: load-extension codes,
// byte-enable patterns and the responder FSM state type.
package dm_responder_pkg;

    localparam logic [2:0] EXT_NONE       = 3'b000;
    localparam logic [2:0] EXT_U_BYTE     = 3'b001;
    localparam logic [2:0] EXT_S_BYTE     = 3'b010;
    localparam logic [2:0] EXT_U_HALFWORD = 3'b011;
    localparam logic [2:0] EXT_S_HALFWORD = 3'b100;

    localparam logic [3:0] BE_WORD   = 4'b1111;
    localparam logic [3:0] BE_HALF_1 = 4'b0011;
    localparam logic [3:0] BE_HALF_2 = 4'b1100;
    localparam logic [3:0] BE_BYTE_1 = 4'b0001;
    localparam logic [3:0] BE_BYTE_2 = 4'b0010;
    localparam logic [3:0] BE_BYTE_3 = 4'b0100;
    localparam logic [3:0] BE_BYTE_4 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dm_responder_load_ext.sv
// Load formatter: picks the addressed byte/halfword out of a memory word and
// zero- or sign-extends it to 32 bits.
module dm_load_ext
    import dm_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ext_op,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    // Halfword selection ignores addr[0]
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_ext_op)
            EXT_U_BYTE:     o_result = {24'd0, w_byte};
            EXT_S_BYTE:     o_result = {{24{w_byte[7]}}, w_byte};
            EXT_U_HALFWORD: o_result = {16'd0, w_half};
            EXT_S_HALFWORD: o_result = {{16{w_half[15]}}, w_half};
            default:        o_result = i_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: single-port word memory with byte-lane writes,
// configurable wait states and one-cycle response pulses.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  byteen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ext_op,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byteen;
    logic [2:0]  r_ext_op;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic [3:0]  w_op_byteen;
    logic [2:0]  w_op_ext;
    logic [AW-1:0] w_idx;
    logic [31:0] w_load;
    logic        w_unused_addr_hi;

    assign ready    = (r_state != WAIT);
    assign w_accept = req && ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                else          w_state_nxt = IDLE;
            end
            WAIT:    if (r_wait_cnt == 4'd0) w_state_nxt = RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With no wait states the accepting edge is also the commit edge, so the
    // live inputs are used; after WAIT the captured request is used instead.
    assign w_enter_resp     = (w_state_nxt == RESP) && !reset;
    assign w_op_addr        = w_accept ? addr   : r_addr;
    assign w_op_wdata       = w_accept ? wdata  : r_wdata;
    assign w_op_byteen      = w_accept ? byteen : r_byteen;
    assign w_op_ext         = w_accept ? ext_op : r_ext_op;
    assign w_idx            = w_op_addr[AW+1:2];
    assign w_unused_addr_hi = ^w_op_addr[31:AW+2];

    dm_load_ext u_load_ext (
        .i_word    (r_mem[w_idx]),
        .i_addr_lo (w_op_addr[1:0]),
        .i_ext_op  (w_op_ext),
        .o_result  (w_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_byteen   <= 4'd0;
            r_ext_op   <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= (w_state_nxt == RESP);
            if (w_accept) begin
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_byteen   <= byteen;
                r_ext_op   <= ext_op;
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_enter_resp) r_rdata <= (w_op_byteen != 4'd0) ? 32'd0 : w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
        end else if (w_enter_resp) begin
            for (int l = 0; l < 4; l++)
                if (w_op_byteen[l]) r_mem[w_idx][8*l +: 8] <= w_op_wdata[8*l +: 8];
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule
